// File: rtl/camera_frame_reader_pkg.sv
// Shared definitions for the camera frame reader.
// Frame geometry defaults, packed-word field positions, the read FSM state
// encoding, the FIFO entry layout and a word-unpacking helper.
package camera_frame_reader_pkg;

    localparam int unsigned DefaultFrameWidth  = 320;
    localparam int unsigned DefaultFrameHeight = 240;
    localparam int unsigned DefaultFramePixels = DefaultFrameWidth * DefaultFrameHeight;
    localparam int unsigned DefaultFifoDepth   = 4;
    localparam int unsigned AddrWidth          = 20;

    // Capture path stores {blue, 8'h00, green, red} per pixel.
    localparam int unsigned RedLsb   = 0;
    localparam int unsigned GreenLsb = 8;
    localparam int unsigned BlueLsb  = 24;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StIssue    = 2'd1,
        StWaitData = 2'd2,
        StDone     = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_entry_t;

    function automatic pixel_entry_t unpack_word(input logic [31:0] word,
                                                 input logic        sof,
                                                 input logic        eol);
        pixel_entry_t e;
        e.sof   = sof;
        e.eol   = eol;
        e.red   = word[RedLsb   +: 8];
        e.green = word[GreenLsb +: 8];
        e.blue  = word[BlueLsb  +: 8];
        return e;
    endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Small synchronous FIFO buffering unpacked pixels (data + sof/eol tags).
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clear_i       synchronous flush (takes priority over push/pop)
//   push_i/wdata_i  write strobe and entry; ignored when full
//   pop_i/rdata_o   read strobe and head entry; pop ignored when empty
//   level_o, full_o, empty_o  occupancy status
module pixel_skid_fifo #(
    parameter int unsigned Width = 26,
    parameter int unsigned Depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic [Width-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [Width-1:0]             rdata_o,
    output logic [$clog2(Depth+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned LW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(Depth));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_q <= level_q + LW'(1);
            else if (do_pop && !do_push) level_q <= level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/camera_frame_reader.sv
// Reads one stored frame from DDR in raster order (one word per pixel at
// offset + index), unpacks RGB and streams it with sof/eol tags through a
// small FIFO under valid/ready backpressure.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   read_enable, read_offset   rising edge starts a read at read_offset; low aborts
//   read_done                  all pixels fetched and drained; held until enable low
//   ddr_addr, ddr_rden, pause  read request interface (no request while pause)
//   data_read, data_read_valid returned word and its strobe
//   pixel_*                    output stream (valid/ready, RGB, sof, eol)
//   fifo_level                 debug FIFO occupancy
module camera_frame_reader #(
    parameter int unsigned FRAME_WIDTH  = camera_frame_reader_pkg::DefaultFrameWidth,
    parameter int unsigned FRAME_HEIGHT = camera_frame_reader_pkg::DefaultFrameHeight,
    parameter int unsigned FIFO_DEPTH   = camera_frame_reader_pkg::DefaultFifoDepth
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [19:0] read_offset,
    output logic        read_done,
    output logic [19:0] ddr_addr,
    output logic        ddr_rden,
    input  logic        pause,
    input  logic [31:0] data_read,
    input  logic        data_read_valid,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [7:0]  pixel_red,
    output logic [7:0]  pixel_green,
    output logic [7:0]  pixel_blue,
    output logic        pixel_sof,
    output logic        pixel_eol,
    output logic [2:0]  fifo_level
);
    import camera_frame_reader_pkg::*;

    localparam int unsigned FramePixels = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int unsigned IdxW        = $clog2(FramePixels + 1);
    localparam int unsigned ColW        = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int unsigned LvlW        = $clog2(FIFO_DEPTH + 1);

    rd_state_e        state_q, state_d;
    logic             en_q;
    logic [19:0]      offset_q, offset_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [ColW-1:0]  col_q, col_d;

    logic             start;
    logic             push, pop, fifo_full, fifo_empty;
    logic [LvlW-1:0]  level;
    pixel_entry_t     wentry, rentry;

    assign start = read_enable & ~en_q;

    // en_q resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            en_q     <= 1'b1;
            offset_q <= '0;
            idx_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            en_q     <= read_enable;
            offset_q <= offset_d;
            idx_q    <= idx_d;
            col_q    <= col_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        idx_d     = idx_q;
        col_d     = col_q;
        ddr_rden  = 1'b0;
        push      = 1'b0;
        read_done = 1'b0;
        if (!read_enable) begin
            // Abort: also drops any late data_read_valid and flushes the FIFO.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        offset_d = read_offset;
                        idx_d    = '0;
                        col_d    = '0;
                        state_d  = StIssue;
                    end
                end
                StIssue: begin
                    // With one request outstanding, a free slot now guarantees room later.
                    if (!pause && !fifo_full) begin
                        ddr_rden = 1'b1;
                        state_d  = StWaitData;
                    end
                end
                StWaitData: begin
                    if (data_read_valid) begin
                        push    = 1'b1;
                        idx_d   = idx_q + IdxW'(1);
                        col_d   = (col_q == ColW'(FRAME_WIDTH - 1)) ? '0 : col_q + ColW'(1);
                        state_d = (idx_q == IdxW'(FramePixels - 1)) ? StDone : StIssue;
                    end
                end
                StDone: begin
                    read_done = fifo_empty;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign ddr_addr = offset_q + 20'(idx_q);
    assign wentry   = unpack_word(data_read, (idx_q == '0),
                                  (col_q == ColW'(FRAME_WIDTH - 1)));

    assign pixel_valid = ~fifo_empty;
    assign pop         = pixel_valid & pixel_ready;

    pixel_skid_fifo #(
        .Width ($bits(pixel_entry_t)),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (~read_enable),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (rentry),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Data is forced to zero when nothing is valid so idle outputs read as 0.
    assign pixel_red   = pixel_valid ? rentry.red   : '0;
    assign pixel_green = pixel_valid ? rentry.green : '0;
    assign pixel_blue  = pixel_valid ? rentry.blue  : '0;
    assign pixel_sof   = pixel_valid & rentry.sof;
    assign pixel_eol   = pixel_valid & rentry.eol;
    assign fifo_level  = 3'(level);

endmodule

// File: tb/tb_camera_frame_reader.sv
module tb_camera_frame_reader;

    localparam int W = 16;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset, read_enable, read_done, ddr_rden, pause;
    logic [19:0] read_offset, ddr_addr;
    logic [31:0] data_read;
    logic        data_read_valid, pixel_valid, pixel_ready, pixel_sof, pixel_eol;
    logic [7:0]  pixel_red, pixel_green, pixel_blue;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    camera_frame_reader #(
        .FRAME_WIDTH  (W),
        .FRAME_HEIGHT (H),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .read_enable     (read_enable),
        .read_offset     (read_offset),
        .read_done       (read_done),
        .ddr_addr        (ddr_addr),
        .ddr_rden        (ddr_rden),
        .pause           (pause),
        .data_read       (data_read),
        .data_read_valid (data_read_valid),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .pixel_red       (pixel_red),
        .pixel_green     (pixel_green),
        .pixel_blue      (pixel_blue),
        .pixel_sof       (pixel_sof),
        .pixel_eol       (pixel_eol),
        .fifo_level      (fifo_level)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic       sof, eol;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          gen = 0, req_cnt = 0, resp_cnt = 0, pix_cnt = 0, rden_total = 0;
    int          lat_min = 0, lat_max = 2;
    logic [19:0] tb_offset = '0;
    logic [19:0] addr16 = '1;
    bit          rnd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // k-th pixel of a ramp frame: colour bytes are the index bytes.
    function automatic exp_t model_pixel(input int k);
        exp_t e;
        e.r   = 8'(k);
        e.g   = 8'(k >> 8);
        e.b   = 8'(k >> 16);
        e.sof = (k == 0);
        e.eol = ((k % W) == W - 1);
        return e;
    endfunction

    function automatic logic [31:0] mem_word(input logic [19:0] addr);
        logic [19:0] i;
        i = addr - tb_offset;
        return {8'(i >> 16), 8'h00, 8'(i >> 8), 8'(i)};
    endfunction

    // Memory controller: one request at a time, random latency.
    initial begin : mem_model
        bit          pend = 0;
        int          pend_cnt = 0, pend_gen = 0, dl_gen = 0;
        logic [31:0] pend_word = '0;
        data_read       = '0;
        data_read_valid = 1'b0;
        forever begin
            @(negedge clk);
            data_read_valid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    data_read       = pend_word;
                    data_read_valid = 1'b1;
                    dl_gen          = pend_gen;
                    pend            = 0;
                end else begin
                    pend_cnt--;
                end
            end
            #1;
            if (data_read_valid && read_enable && !reset && dl_gen == gen) begin
                exp_q.push_back(model_pixel(resp_cnt));
                resp_cnt++;
            end
            if (ddr_rden && !reset) begin
                chk("rden_while_pause", {31'd0, pause}, 0);
                chk("rden_with_room", {31'd0, (fifo_level < 3'd4)}, 1);
                chk("single_outstanding", {31'd0, pend}, 0);
                chk("ddr_addr", {12'd0, ddr_addr}, {12'd0, 20'(tb_offset + 20'(req_cnt))});
                if (req_cnt == 16) addr16 = ddr_addr;
                req_cnt++;
                rden_total++;
                pend      = 1;
                pend_cnt  = $urandom_range(lat_max, lat_min);
                pend_word = mem_word(ddr_addr);
                pend_gen  = gen;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        bit          hold = 0;
        logic [25:0] held = '0;
        logic [25:0] cur;
        exp_t        e;
        forever begin
            @(negedge clk);
            #1;
            cur = {pixel_sof, pixel_eol, pixel_red, pixel_green, pixel_blue};
            if (reset || !read_enable) begin
                exp_q.delete();
                hold = 0;
            end else begin
                if (hold && pixel_valid) chk("stable_while_stalled", {6'd0, cur}, {6'd0, held});
                if (pixel_valid && pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pixel", {6'd0, cur}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pixel", {6'd0, cur}, {6'd0, e.sof, e.eol, e.r, e.g, e.b});
                        pix_cnt++;
                    end
                end
                hold = pixel_valid && !pixel_ready;
                held = cur;
            end
        end
    end

    initial begin : rand_drive
        forever begin
            @(negedge clk);
            if (rnd) begin
                pause       = ($urandom_range(4, 0) == 0);
                pixel_ready = ($urandom_range(3, 0) != 0);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got still running, required finished");
        $fatal(1, "time limit");
    end

    task automatic start_frame(input logic [19:0] off);
        @(negedge clk);
        read_enable = 1'b0;
        @(negedge clk);
        gen++;
        tb_offset   = off;
        read_offset = off;
        req_cnt     = 0;
        resp_cnt    = 0;
        pix_cnt     = 0;
        addr16      = '1;
        read_enable = 1'b1;
    endtask

    task automatic wait_pix(input int n);
        int k = 0;
        while (pix_cnt < n && k < 3000) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("wait_pix_bound", {31'd0, (pix_cnt >= n)}, 1);
    endtask

    task automatic finish_frame(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!read_done && k < 4000);
        chk({name, "_done"}, {31'd0, read_done}, 1);
        chk({name, "_pixels"}, pix_cnt, N);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
        chk({name, "_drained"}, {28'd0, pixel_valid, fifo_level}, 0);
        @(negedge clk);
        #2;
        chk({name, "_done_held"}, {31'd0, read_done}, 1);
        @(negedge clk);
        read_enable = 1'b0;
        #2;
        chk({name, "_done_cleared"}, {31'd0, read_done}, 0);
        @(negedge clk);
        #2;
        chk({name, "_idle"}, {30'd0, read_done, ddr_rden}, 0);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, {31'd0, pixel_valid}, 0);
        chk({name, "_done"}, {31'd0, read_done}, 0);
        chk({name, "_rden"}, {31'd0, ddr_rden}, 0);
        chk({name, "_level"}, {29'd0, fifo_level}, 0);
        chk({name, "_addr"}, {12'd0, ddr_addr}, 0);
        chk({name, "_data"}, {6'd0, pixel_sof, pixel_eol, pixel_red, pixel_green, pixel_blue}, 0);
    endtask

    initial begin : stimulus
        int k0;
        int k;
        reset       = 1'b1;
        read_enable = 1'b1;
        read_offset = '0;
        pause       = 1'b0;
        pixel_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        check_zero("reset");
        // Level already high at reset release must not start a read.
        k0 = rden_total;
        repeat (10) @(negedge clk);
        #2;
        chk("no_start_on_high_level", rden_total - k0, 0);

        // Plain ramp frame.
        start_frame(20'h01000);
        finish_frame("ramp");

        // Pause held mid-frame.
        start_frame(20'h00200);
        wait_pix(30);
        @(negedge clk);
        pause = 1'b1;
        k0 = rden_total;
        repeat (50) @(negedge clk);
        #2;
        chk("rden_during_pause", rden_total - k0, 0);
        @(negedge clk);
        pause = 1'b0;
        finish_frame("pause");

        // Consumer stall fills the FIFO.
        start_frame(20'h03000);
        wait_pix(20);
        @(negedge clk);
        pixel_ready = 1'b0;
        repeat (16) @(negedge clk);
        k0 = rden_total;
        repeat (4) @(negedge clk);
        #2;
        chk("stall_level_full", {29'd0, fifo_level}, 4);
        chk("stall_valid", {31'd0, pixel_valid}, 1);
        chk("stall_no_rden", rden_total - k0, 0);
        @(negedge clk);
        pixel_ready = 1'b1;
        finish_frame("stall");

        // Abort with a request in flight, then restart.
        lat_min = 2;
        lat_max = 3;
        start_frame(20'h04000);
        wait_pix(40);
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!ddr_rden && k < 50);
        chk("abort_req_seen", {31'd0, ddr_rden}, 1);
        @(negedge clk);
        read_enable = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        chk("abort_flushed", {28'd0, pixel_valid, fifo_level}, 0);
        lat_min = 0;
        lat_max = 2;
        start_frame(20'h04000);
        finish_frame("restart");

        // Reset mid-frame with read_enable held high.
        start_frame(20'h05000);
        rnd = 1;
        wait_pix(25);
        @(negedge clk);
        rnd         = 0;
        pause       = 1'b0;
        pixel_ready = 1'b1;
        reset       = 1'b1;
        gen++;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check_zero("midreset");
        k0 = rden_total;
        repeat (20) @(negedge clk);
        #2;
        chk("midreset_no_restart", rden_total - k0, 0);
        start_frame(20'h05000);
        finish_frame("after_reset");

        // Address wrap near the top of the 20-bit space.
        rnd = 1;
        start_frame(20'hFFFF0);
        finish_frame("wrap");
        chk("wrap_addr16", {12'd0, addr16}, 0);

        // Random offsets under random pause/backpressure.
        for (int f = 0; f < 2; f++) begin
            start_frame(20'($urandom));
            finish_frame("random");
        end
        rnd = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
